// File: rtl/rom_stream_reader.sv
// Sweeps an address window of a combinational ROM and streams the words out through a small FIFO.
// ROM reads stall whenever the FIFO cannot take another word.
module rom_stream_reader #(
  parameter int unsigned AddrW = 3,
  parameter int unsigned DataW = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [AddrW-1:0]           base_addr_i,
  input  logic [AddrW:0]             length_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       rom_cs_o,
  output logic [AddrW-1:0]           rom_addr_o,
  input  logic [DataW-1:0]           rom_data_i,
  output logic                       out_valid_o,
  output logic [DataW-1:0]           out_data_o,
  input  logic                       out_ready_i,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e            state_q, state_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [AddrW:0]    rem_q, rem_d;
  logic              done_q, done_d;

  logic [DataW-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic full, pop, push, issue;

  assign full  = (count_q == CntW'(Depth));
  assign pop   = (count_q != '0) && out_ready_i;
  // A full FIFO can still accept a word if the head leaves on the same edge.
  assign issue = (state_q == StRead) && (!full || pop);
  assign push  = issue;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (length_i != '0) begin
            state_d = StRead;
            addr_d  = base_addr_i;
            rem_d   = length_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (issue) begin
          rem_d = rem_q - (AddrW + 1)'(1);
          // The last issued address is kept so rom_addr holds it after the sweep.
          if (rem_q == (AddrW + 1)'(1)) begin
            state_d = StDrain;
          end else begin
            addr_d = addr_q + AddrW'(1);
          end
        end
      end
      StDrain: begin
        if (count_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= rom_data_i;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q | ((state_q == StDrain) && (count_q == '0));
  assign rom_cs_o    = issue;
  assign rom_addr_o  = addr_q;
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;

endmodule
